// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a downstream JK flop: buffers {op,rep} commands in a FIFO,
// replays each on registered j/k, and checks the flop's q against a shadow model.
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [REP_W-1:0]       cmd_rep,
  output logic                   j,
  output logic                   k,
  input  logic                   q_fb,
  input  logic                   chk_en,
  input  logic                   clr_mismatch,
  output logic                   expect_q,
  output logic                   mismatch,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam int unsigned GCNT_W   = (GAP == 0) ? 1 : $clog2(GAP + 1);
  localparam int unsigned GAP_LOAD = (GAP == 0) ? 0 : GAP - 1;

  typedef struct packed {
    logic [1:0]       op;
    logic [REP_W-1:0] rep;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  cmd_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              fifo_empty;
  logic              push_c;
  logic              pop_c;
  cmd_t              head;

  state_t            state_q, state_d;
  logic [REP_W-1:0]  cnt_q, cnt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              j_d, k_d;
  logic              load_c;

  assign fifo_empty = (level_q == '0);
  assign cmd_ready  = (level_q != LVL_W'(DEPTH));
  assign push_c     = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  // FIFO storage; flushing is done through the pointers, so the array needs no reset
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= cmd_t'{op: cmd_op, rep: cmd_rep};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      j       <= 1'b0;
      k       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      j       <= j_d;
      k       <= k_d;
    end
  end

  // Next-state: every path that ends a command or gap may load the head entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      S_IDLE: load_c = !fifo_empty;
      S_ISSUE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - REP_W'(1);
          j_d   = j;
          k_d   = k;
        end else if (GAP > 0) begin
          state_d = S_GAP;
          gcnt_d  = GCNT_W'(GAP_LOAD);
        end else if (!fifo_empty) begin
          load_c = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GCNT_W'(1);
        end else if (!fifo_empty) begin
          load_c = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_c) begin
      state_d = S_ISSUE;
      cnt_d   = head.rep;
      j_d     = head.op[1];
      k_d     = head.op[0];
    end
    pop_c = load_c;
  end

  // Shadow JK flop and sticky divergence flag (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expect_q <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   expect_q <= 1'b0;
        2'b10:   expect_q <= 1'b1;
        2'b11:   expect_q <= ~expect_q;
        default: expect_q <= expect_q;
      endcase
      if (chk_en && (q_fb != expect_q)) mismatch <= 1'b1;
      else if (clr_mismatch)            mismatch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: GAP=0 and GAP=2 instances driven in parallel, each
// checked every cycle against a queue-based command-expansion model plus literals.
module tb_jk_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned REP_W = 4;

  logic             clk          = 1'b0;
  logic             rst          = 1'b0;
  logic             cmd_valid    = 1'b0;
  logic [1:0]       cmd_op       = 2'b00;
  logic [REP_W-1:0] cmd_rep      = '0;
  logic             chk_en       = 1'b0;
  logic             clr_mismatch = 1'b0;
  logic             inj          = 1'b0;

  logic       j_w [2];
  logic       k_w [2];
  logic       eq_w [2];
  logic       mm_w [2];
  logic       busy_w [2];
  logic       rdy_w [2];
  logic       qfb_w [2];
  logic [2:0] lvl_w [2];

  logic [5:0] m_fifo [2][$];
  logic [1:0] m_play [2][$];
  logic [1:0] m_jk [2];
  logic       m_act [2];
  logic       m_q [2];
  logic       m_mm [2];

  logic [1:0] t3_jk [5];
  logic       t3_q [5];
  logic [1:0] t4_a [5];
  logic [1:0] t4_b [5];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic fq;

    jk_cmd_sequencer #(
      .DEPTH(DEPTH),
      .REP_W(REP_W),
      .GAP  ((g == 0) ? 0 : 2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (rdy_w[g]),
      .cmd_op      (cmd_op),
      .cmd_rep     (cmd_rep),
      .j           (j_w[g]),
      .k           (k_w[g]),
      .q_fb        (qfb_w[g]),
      .chk_en      (chk_en),
      .clr_mismatch(clr_mismatch),
      .expect_q    (eq_w[g]),
      .mismatch    (mm_w[g]),
      .busy        (busy_w[g]),
      .fifo_level  (lvl_w[g])
    );

    // The JK flop being driven; inj flips its fed-back q to provoke divergence
    always @(posedge clk or posedge rst) begin
      if (rst) fq <= 1'b0;
      else begin
        case ({j_w[g], k_w[g]})
          2'b01:   fq <= 1'b0;
          2'b10:   fq <= 1'b1;
          2'b11:   fq <= ~fq;
          default: fq <= fq;
        endcase
      end
    end
    assign qfb_w[g] = fq ^ inj;
  end

  task automatic check(input string name, input int g, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", name, g, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int g);
    m_fifo[g].delete();
    m_play[g].delete();
    m_jk[g]  = 2'b00;
    m_act[g] = 1'b0;
    m_q[g]   = 1'b0;
    m_mm[g]  = 1'b0;
  endtask

  // One clock edge: each popped command expands into rep+1 op cycles then GAP idle cycles
  task automatic model_tick(input int g);
    int         sz;
    int         gap;
    logic [5:0] c;
    logic [1:0] jk_now;
    if (rst) begin
      model_reset(g);
      return;
    end
    gap    = (g == 0) ? 0 : 2;
    jk_now = m_jk[g];
    sz     = m_fifo[g].size();
    if (chk_en && (qfb_w[g] !== m_q[g])) m_mm[g] = 1'b1;
    else if (clr_mismatch)                m_mm[g] = 1'b0;
    case (jk_now)
      2'b01:   m_q[g] = 1'b0;
      2'b10:   m_q[g] = 1'b1;
      2'b11:   m_q[g] = ~m_q[g];
      default: m_q[g] = m_q[g];
    endcase
    if (m_play[g].size() == 0 && sz != 0) begin
      c = m_fifo[g].pop_front();
      for (int i = 0; i <= int'(c[3:0]); i++) m_play[g].push_back(c[5:4]);
      for (int i = 0; i < gap; i++) m_play[g].push_back(2'b00);
    end
    if (m_play[g].size() != 0) begin
      m_jk[g]  = m_play[g].pop_front();
      m_act[g] = 1'b1;
    end else begin
      m_jk[g]  = 2'b00;
      m_act[g] = 1'b0;
    end
    if (cmd_valid && sz < int'(DEPTH)) m_fifo[g].push_back({cmd_op, cmd_rep});
  endtask

  task automatic compare_all();
    for (int g = 0; g < 2; g++) begin
      check("j",          g, 8'(j_w[g]),    8'(m_jk[g][1]));
      check("k",          g, 8'(k_w[g]),    8'(m_jk[g][0]));
      check("expect_q",   g, 8'(eq_w[g]),   8'(m_q[g]));
      check("mismatch",   g, 8'(mm_w[g]),   8'(m_mm[g]));
      check("fifo_level", g, 8'(lvl_w[g]),  8'(m_fifo[g].size()));
      check("cmd_ready",  g, 8'(rdy_w[g]),  8'(m_fifo[g].size() < int'(DEPTH)));
      check("busy",       g, 8'(busy_w[g]), 8'(m_act[g] || (m_fifo[g].size() != 0)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick(0);
    model_tick(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    chk_en       = 1'b0;
    clr_mismatch = 1'b0;
    inj          = 1'b0;
    model_reset(0);
    model_reset(1);
    steps(2);
    rst = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    t3_jk = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    t3_q  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t4_a  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    t4_b  = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00};

    #1;
    do_reset();

    // Reset in the middle of a toggle rep=7 run
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rep = 4'd7;
    step();
    cmd_valid = 1'b0;
    steps(3);
    check("run_before_rst", 0, 8'({j_w[0], k_w[0]}), 8'd3);
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rst_jk",       g, 8'({j_w[g], k_w[g]}), 8'd0);
      check("rst_level",    g, 8'(lvl_w[g]),  8'd0);
      check("rst_ready",    g, 8'(rdy_w[g]),  8'd1);
      check("rst_expect_q", g, 8'(eq_w[g]),   8'd0);
      check("rst_busy",     g, 8'(busy_w[g]), 8'd0);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_jk", 0, 8'({j_w[0], k_w[0]}), 8'd0);
    end

    // Single set, rep=0
    chk_en = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rep = 4'd0;
    step();
    check("set_level_e0", 0, 8'(lvl_w[0]), 8'd1);
    cmd_valid = 1'b0;
    step();
    check("set_jk_e1",    0, 8'({j_w[0], k_w[0]}), 8'd2);
    check("set_level_e1", 0, 8'(lvl_w[0]), 8'd0);
    check("set_q_e1",     0, 8'(eq_w[0]),  8'd0);
    step();
    check("set_jk_e2",    0, 8'({j_w[0], k_w[0]}), 8'd0);
    check("set_q_e2",     0, 8'(eq_w[0]),  8'd1);
    check("set_qfb_e2",   0, 8'(qfb_w[0]), 8'd1);
    step();
    check("set_mismatch", 0, 8'(mm_w[0]),  8'd0);

    // Toggle burst rep=3
    do_reset();
    chk_en = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rep = 4'd3;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("tog_jk",  0, 8'({j_w[0], k_w[0]}), 8'(t3_jk[i]));
      check("tog_q",   0, 8'(eq_w[0]),  8'(t3_q[i]));
      check("tog_qfb", 0, 8'(qfb_w[0]), 8'(t3_q[i]));
    end
    check("tog_busy_end", 0, 8'(busy_w[0]), 8'd0);
    check("tog_mismatch", 0, 8'(mm_w[0]),   8'd0);

    // Back-to-back (inst0) versus two-cycle gap (inst1)
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rep = 4'd0;
    step();
    cmd_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) cmd_valid = 1'b0;
      check("b2b_jk", 0, 8'({j_w[0], k_w[0]}), 8'(t4_a[i]));
      check("gap_jk", 1, 8'({j_w[1], k_w[1]}), 8'(t4_b[i]));
    end

    // FIFO full behind a long hold; fifth command must stall, not drop
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rep = 4'd15;
    step();
    cmd_op = 2'b10; cmd_rep = 4'd1; step();
    cmd_op = 2'b01; cmd_rep = 4'd0; step();
    cmd_op = 2'b11; cmd_rep = 4'd2; step();
    cmd_op = 2'b10; cmd_rep = 4'd0; step();
    check("full_level", 0, 8'(lvl_w[0]), 8'd4);
    check("full_ready", 0, 8'(rdy_w[0]), 8'd0);
    cmd_op = 2'b01; cmd_rep = 4'd0;
    step();
    check("stall_level", 0, 8'(lvl_w[0]), 8'd4);
    check("stall_ready", 0, 8'(rdy_w[0]), 8'd0);
    n = 0;
    while (!rdy_w[0] && n < 40) begin
      step();
      n++;
    end
    check("ready_wait",   0, 8'(n), 8'd12);
    check("pop_level",    0, 8'(lvl_w[0]), 8'd3);
    step();
    cmd_valid = 1'b0;
    check("refill_level", 0, 8'(lvl_w[0]), 8'd4);
    check("refill_jk",    0, 8'({j_w[0], k_w[0]}), 8'd2);
    n = 0;
    while ((busy_w[0] || busy_w[1]) && n < 80) begin
      step();
      n++;
    end
    check("drain_busy", 0, 8'(busy_w[0] | busy_w[1]), 8'd0);

    // Sticky mismatch, clear, and set-beats-clear
    do_reset();
    chk_en = 1'b1;
    steps(2);
    check("mm_idle", 0, 8'(mm_w[0]), 8'd0);
    inj = 1'b1;
    step();
    inj = 1'b0;
    check("mm_set", 0, 8'(mm_w[0]), 8'd1);
    steps(3);
    check("mm_sticky", 0, 8'(mm_w[0]), 8'd1);
    clr_mismatch = 1'b1;
    step();
    clr_mismatch = 1'b0;
    check("mm_clr", 0, 8'(mm_w[0]), 8'd0);
    step();
    check("mm_clr_hold", 0, 8'(mm_w[0]), 8'd0);
    inj = 1'b1;
    clr_mismatch = 1'b1;
    step();
    inj = 1'b0;
    clr_mismatch = 1'b0;
    check("mm_set_wins", 0, 8'(mm_w[0]), 8'd1);
    step();
    check("mm_after_race", 0, 8'(mm_w[0]), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
